spi_reg_responder: RTL and testbench

SPI slave that emulates an ADXL362-style register-mapped peripheral on the system SPI bus, acting as the far end of the AHB SPI master. The block oversamples SCLK/SS/MOSI on the system clock, decodes read/write command frames, and serves a 64-byte register file with address auto-increment. Fabric logic updates registers via a host port (e.g. sensor samples) and observes SPI writes via a strobe port; stands in for the accelerometer in simulation and on-board loopback tests.

---
 rtl/spi_reg_responder.sv | 178 +++++++++++++++++
 tb/tb_spi_reg_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave serving a 64-byte register file (ADXL362-style read/write framing).
// Pins are oversampled on clk; the host port writes registers and SPI writes are reported on reg_wr_o.
module spi_reg_responder #(
  parameter logic [7:0]  ID_VALUE = 8'hAD,
  parameter int unsigned RO_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk_i,
  input  logic       spi_ss_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic       host_we_i,
  input  logic [5:0] host_addr_i,
  input  logic [7:0] host_wdata_i,
  output logic       reg_wr_o,
  output logic [5:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       busy_o
);

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;
  localparam logic [6:0] RO_LIM = 7'(RO_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic        sclk_dly_q;
  logic        armed_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  rx_q, tx_q;
  logic [5:0]  addr_q;
  logic        is_read_q;
  logic        miso_q;
  logic        reg_wr_q;
  logic [5:0]  reg_addr_q;
  logic [7:0]  reg_wdata_q;
  logic [7:0]  regs_q [0:63];

  logic        sclk_s, ss_s, mosi_s;
  logic        sclk_rise, sclk_fall;
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic        spi_we;
  logic [5:0]  rd_sel;
  logic [7:0]  rd_data;

  assign sclk_s    = sclk_sync_q[1];
  assign ss_s      = ss_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (bitcnt_q == 3'd7) && !ss_s;
  assign spi_we    = (state_q == ST_WDATA) && byte_done && ({1'b0, addr_q} >= RO_LIM);
  // The address byte itself selects the first read register, before addr_q is updated.
  assign rd_sel    = (state_q == ST_ADDR) ? rx_byte[5:0] : addr_q;
  assign rd_data   = regs_q[rd_sel];

  // ss sync resets low so a frame already in progress at reset is not picked up mid-way.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
      ss_sync_q   <= {ss_sync_q[0], spi_ss_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      sclk_dly_q  <= sclk_s;
      if (ss_s) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (!ss_s && armed_q) state_d = ST_CMD;
    end else if (ss_s) begin
      state_d = ST_IDLE;
    end else if (byte_done) begin
      case (state_q)
        ST_CMD:  state_d = (rx_byte == CMD_WR || rx_byte == CMD_RD) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: state_d = is_read_q ? ST_RDATA : ST_WDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    spi_miso_oe_o = busy_o;
    spi_miso_o    = miso_q;
    reg_wr_o      = reg_wr_q;
    reg_addr_o    = reg_addr_q;
    reg_wdata_o   = reg_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt_q    <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      reg_wr_q <= 1'b0;
      miso_q   <= (state_q == ST_RDATA) ? tx_q[7] : 1'b0;
      if (state_q == ST_IDLE || ss_s) begin
        bitcnt_q <= '0;
      end else if (sclk_rise) begin
        rx_q     <= rx_byte;
        bitcnt_q <= bitcnt_q + 3'd1;
      end
      // The falling edge right after a load belongs to the previous byte and must not shift.
      if (state_q == ST_RDATA && sclk_fall && bitcnt_q != 3'd0)
        tx_q <= {tx_q[6:0], 1'b0};
      if (byte_done) begin
        case (state_q)
          ST_CMD: is_read_q <= (rx_byte == CMD_RD);
          ST_ADDR: begin
            if (is_read_q) begin
              tx_q   <= rd_data;
              addr_q <= rx_byte[5:0] + 6'd1;
            end else begin
              addr_q <= rx_byte[5:0];
            end
          end
          ST_WDATA: begin
            if (spi_we) begin
              reg_wr_q    <= 1'b1;
              reg_addr_q  <= addr_q;
              reg_wdata_q <= rx_byte;
            end
            addr_q <= addr_q + 6'd1;
          end
          ST_RDATA: begin
            tx_q   <= rd_data;
            addr_q <= addr_q + 6'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Entry 0 holds ID_VALUE from reset and is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q[0] <= ID_VALUE;
      for (int i = 1; i < 64; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < 64; i++) begin
        if (host_we_i && host_addr_i == 6'(i))
          regs_q[i] <= host_wdata_i;
        else if (spi_we && addr_q == 6'(i))
          regs_q[i] <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: a frame-level register model predicts MISO bytes and write strobes.
module tb_spi_reg_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe;
  logic       host_we = 1'b0;
  logic [5:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       reg_wr;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:63];
  logic [7:0]  fbytes [$];
  logic [7:0]  rxq [$];
  logic [7:0]  exp_rx [$];
  logic [13:0] wq [$];
  logic [5:0]  coll_addr = '0;
  logic [7:0]  coll_data = '0;
  logic        prev_wr = 1'b0;

  always #5 clk = ~clk;

  spi_reg_responder dut (
    .clk          (clk),
    .reset        (rst),
    .spi_sclk_i   (sclk),
    .spi_ss_i     (ss),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (miso),
    .spi_miso_oe_o(miso_oe),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .reg_wr_o     (reg_wr),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .busy_o       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'hAD;
  endtask

  task automatic host_model(input logic [5:0] a, input logic [7:0] d);
    if (a != 6'd0) mem[a] = d;
  endtask

  // Frame-level prediction: full bytes only, addresses below 8 are read-only from SPI.
  task automatic model_frame(input int last_bits, input int coll_byte);
    int nfull;
    logic [7:0] cmd;
    logic [5:0] a;
    nfull = (last_bits == 8) ? fbytes.size() : fbytes.size() - 1;
    exp_rx.delete();
    for (int b = 0; b < nfull; b++) exp_rx.push_back(8'h00);
    cmd = fbytes[0];
    if (nfull >= 2 && (cmd == 8'h0A || cmd == 8'h0B)) begin
      a = fbytes[1][5:0];
      for (int b = 2; b < nfull; b++) begin
        if (cmd == 8'h0A) begin
          if (a >= 6'd8) begin
            wq.push_back({a, fbytes[b]});
            mem[a] = fbytes[b];
          end
          if (b == coll_byte) host_model(coll_addr, coll_data);
        end else begin
          exp_rx[b] = mem[a];
        end
        a = a + 6'd1;
      end
    end
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    host_model(a, d);
  endtask

  // Mode-0 master, 8 clk per SCLK phase; MISO sampled as SCLK rises.
  task automatic run_frame(input int last_bits, input int coll_byte, input bit chk_busy);
    logic [7:0] rxb;
    int nb, nbits;
    rxq.delete();
    nb = fbytes.size();
    ss = 1'b0;
    repeat (8) @(negedge clk);
    if (chk_busy) chk("busy_in_frame", busy, 1);
    for (int b = 0; b < nb; b++) begin
      nbits = (b == nb - 1) ? last_bits : 8;
      rxb = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
        mosi = fbytes[b][i];
        repeat (8) @(negedge clk);
        sclk = 1'b1;
        rxb = {rxb[6:0], miso};
        if (b == coll_byte && i == 0) begin
          repeat (2) @(negedge clk);
          host_we = 1'b1; host_addr = coll_addr; host_wdata = coll_data;
          @(negedge clk);
          host_we = 1'b0;
          repeat (5) @(negedge clk);
        end else begin
          repeat (8) @(negedge clk);
        end
        sclk = 1'b0;
      end
      if (nbits == 8) rxq.push_back(rxb);
    end
    repeat (8) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_after_frame", busy, 0);
    chk("writes_outstanding", wq.size(), 0);
  endtask

  task automatic check_rx(input string name);
    chk({name, "_rx_count"}, rxq.size(), exp_rx.size());
    for (int i = 0; i < rxq.size() && i < exp_rx.size(); i++)
      chk({name, "_rx_byte"}, {i[23:0], rxq[i]}, {i[23:0], exp_rx[i]});
  endtask

  // Every-cycle compare: OE tracks busy, MISO quiet when idle, write strobes match the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("oe_eq_busy", miso_oe, busy);
      if (!busy) chk("miso_idle", miso, 0);
      if (reg_wr) begin
        if (prev_wr) chk("wr_pulse_width", 1, 0);
        if (wq.size() == 0) begin
          chk("unexpected_write", {reg_addr, reg_wdata}, 0);
          chk("unexpected_write_cnt", 1, 0);
        end else begin
          chk("write_strobe", {reg_addr, reg_wdata}, wq.pop_front());
        end
      end
      prev_wr = reg_wr;
    end else begin
      prev_wr = 1'b0;
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_wr", reg_wr, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Write with auto-increment.
    fbytes = '{8'h0A, 8'h20, 8'h55, 8'hAA};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("wr20");
    chk("hold_addr", reg_addr, 6'h21);
    chk("hold_wdata", reg_wdata, 8'hAA);
    chk("model_20", mem[6'h20], 8'h55);

    // Host writes RO registers, then read from 0x00.
    host_write(6'h01, 8'h1D);
    host_write(6'h02, 8'hF2);
    fbytes = '{8'h0B, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("rd00");
    chk("lit_rd0", rxq[2], 8'hAD);
    chk("lit_rd1", rxq[3], 8'h1D);
    chk("lit_rd2", rxq[4], 8'hF2);

    // Wrap at 0x3F: write to 0x00 blocked, ID reads back.
    fbytes = '{8'h0A, 8'h3F, 8'h11, 8'h22};
    model_frame(8, -1); run_frame(8, -1, 1);
    fbytes = '{8'h0B, 8'h3F, 8'h00, 8'h00};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("rd3f");
    chk("lit_wrap0", rxq[2], 8'h11);
    chk("lit_wrap1", rxq[3], 8'hAD);

    // Read-only address from SPI.
    fbytes = '{8'h0A, 8'h05, 8'h77};
    model_frame(8, -1); run_frame(8, -1, 1);
    fbytes = '{8'h0B, 8'h05, 8'h00};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("rd05");
    chk("lit_ro05", rxq[2], 8'h00);

    // Partial data byte, then an unknown command.
    fbytes = '{8'h0A, 8'h30, 8'hC3};
    model_frame(5, -1); run_frame(5, -1, 1);
    fbytes = '{8'h3C, 8'h20, 8'hFF};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("ignore");
    fbytes = '{8'h0B, 8'h2F, 8'h00, 8'h00};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("rd2f");
    chk("lit_partial30", rxq[3], 8'h00);

    // Host and SPI hit 0x30 on the same clock: host data lands, strobe carries SPI data.
    coll_addr = 6'h30; coll_data = 8'h99;
    fbytes = '{8'h0A, 8'h30, 8'h44};
    model_frame(8, 2); run_frame(8, 2, 1);
    chk("lit_coll_strobe", reg_wdata, 8'h44);
    fbytes = '{8'h0B, 8'h30, 8'h00};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("rdcoll");
    chk("lit_coll_reg", rxq[2], 8'h99);

    // Reset in mid-frame: the rest of that frame must be ignored.
    fbytes = '{8'h0A, 8'h31, 8'h66};
    fork
      run_frame(8, -1, 1);
      begin
        repeat (100) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_oe", miso_oe, 0);
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_wr", reg_wr, 0);
        chk("mid_rst_addr", reg_addr, 0);
        chk("mid_rst_wdata", reg_wdata, 0);
        rst = 1'b0;
        model_reset();
        repeat (40) @(negedge clk);
        chk("mid_rst_unarmed", busy, 0);
      end
    join
    fbytes = '{8'h0A, 8'h31, 8'h66};
    model_frame(8, -1); run_frame(8, -1, 1);
    fbytes = '{8'h0B, 8'h30, 8'h00, 8'h00};
    model_frame(8, -1); run_frame(8, -1, 1); check_rx("rdpost");
    chk("lit_post30", rxq[2], 8'h00);
    chk("lit_post31", rxq[3], 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
